// File: rtl/st2_ctrl_pkg.sv
// Shared decode constants, state encoding and control-word layout for the
// stage-2 (decode) pipeline controller.
package st2_ctrl_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned INSN_W = 16;

    localparam logic [OPC_W-1:0] OP_RTYPE = 4'h0;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'h4;
    localparam logic [OPC_W-1:0] OP_ANDI  = 4'h6;
    localparam logic [OPC_W-1:0] OP_ORI   = 4'h7;
    localparam logic [OPC_W-1:0] OP_LW    = 4'h8;
    localparam logic [OPC_W-1:0] OP_SW    = 4'hB;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'hC;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

    localparam logic [OPC_W-1:0] FN_MUL = 4'h4;
    localparam logic [OPC_W-1:0] FN_DIV = 4'h5;

    localparam logic [SEL_W-1:0] SE_S4  = 2'b00;
    localparam logic [SEL_W-1:0] SE_S8  = 2'b01;
    localparam logic [SEL_W-1:0] SE_S12 = 2'b10;
    localparam logic [SEL_W-1:0] SE_Z8  = 2'b11;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        MULDIV   = 2'd2,
        HALT     = 2'd3
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_word_t;

    // Opcodes outside the decoded set behave as NOPs.
    function automatic logic is_nop(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_ANDI, OP_ORI,
            OP_LW, OP_SW, OP_JMP, OP_HALT: is_nop = 1'b0;
            default:                       is_nop = 1'b1;
        endcase
    endfunction

    function automatic ctrl_word_t decode_ctrl(input logic [OPC_W-1:0] op);
        ctrl_word_t c;
        c = '0;
        case (op)
            OP_RTYPE:        c.reg_write = 1'b1;
            OP_ANDI, OP_ORI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
            OP_LW:           begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; end
            OP_SW:           begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
            OP_BEQ:          c.branch = 1'b1;
            OP_JMP:          c.jump = 1'b1;
            default:         c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [SEL_W-1:0] decode_se(input logic [OPC_W-1:0] op);
        case (op)
            OP_ANDI, OP_ORI: decode_se = SE_Z8;
            OP_BEQ:          decode_se = SE_S8;
            OP_JMP:          decode_se = SE_S12;
            default:         decode_se = SE_S4;
        endcase
    endfunction

endpackage

// File: rtl/st2_pipeline_ctrl_if.sv
// Decode-stage controller bus: IF/ID and EX-side inputs, control outputs.
interface st2_pipeline_ctrl_if;
    import st2_ctrl_pkg::*;

    logic [INSN_W-1:0] ifid_instr;
    logic              idex_mem_read;
    logic [OPC_W-1:0]  idex_dst;
    logic              ex_branch_taken;
    logic [SEL_W-1:0]  se_sel;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic              branch;
    logic              jump;
    logic              halted;

    modport master (
        output ifid_instr, idex_mem_read, idex_dst, ex_branch_taken,
        input  se_sel, pc_we, ifid_we, ifid_flush, idex_bubble,
               reg_write, mem_read, mem_write, alu_src, branch, jump, halted
    );

    modport slave (
        input  ifid_instr, idex_mem_read, idex_dst, ex_branch_taken,
        output se_sel, pc_we, ifid_we, ifid_flush, idex_bubble,
               reg_write, mem_read, mem_write, alu_src, branch, jump, halted
    );

endinterface

// File: rtl/st2_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds
// either source field of a real (non-NOP) instruction in IF/ID.
module st2_hazard_detect
    import st2_ctrl_pkg::*;
(
    input  logic             idex_mem_read,
    input  logic [OPC_W-1:0] idex_dst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] op1,
    input  logic [OPC_W-1:0] op2,
    output logic             lu_stall
);

    assign lu_stall = idex_mem_read && !is_nop(opcode) &&
                      ((idex_dst == op1) || (idex_dst == op2));

endmodule

// File: rtl/st2_pipeline_ctrl.sv
// Stage-2 decode controller: control word, sign-extend select and pipeline
// sequencing (load-use stall, branch flush, halt). Optional multiply/divide
// hold is built when ST2_MULDIV_STALL_EN is defined.
module st2_pipeline_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    st2_pipeline_ctrl_if.slave    bus
);
    import st2_ctrl_pkg::*;

    if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("st2_pipeline_ctrl: MUL_CYCLES out of range 2..15");
    end

    logic [OPC_W-1:0] opcode;
    logic             lu_stall;
    ctrl_word_t       dec_ctrl;
    state_t           state_q, state_d;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble;

    assign opcode   = bus.ifid_instr[15:12];
    assign dec_ctrl = decode_ctrl(opcode);

    st2_hazard_detect u_hazard (
        .idex_mem_read (bus.idex_mem_read),
        .idex_dst      (bus.idex_dst),
        .opcode        (opcode),
        .op1           (bus.ifid_instr[11:8]),
        .op2           (bus.ifid_instr[7:4]),
        .lu_stall      (lu_stall)
    );

`ifdef ST2_MULDIV_STALL_EN
    localparam int unsigned CNT_W = 4;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_muldiv;

    assign is_muldiv = (opcode == OP_RTYPE) &&
                       ((bus.ifid_instr[3:0] == FN_MUL) || (bus.ifid_instr[3:0] == FN_DIV));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RST_HOLD;
        else        state_q <= state_d;
    end

    // Next state and pipeline enables; default is a full hold with a bubble.
    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
`ifdef ST2_MULDIV_STALL_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            RST_HOLD: begin
                ifid_flush = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (bus.ex_branch_taken) begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                end else if (lu_stall) begin
                    state_d = RUN;
                end else if (opcode == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    idex_bubble = 1'b0;
`ifdef ST2_MULDIV_STALL_EN
                    if (is_muldiv) begin
                        state_d = MULDIV;
                        cnt_d   = CNT_W'(MUL_CYCLES - 1);
                    end
`endif
                end
            end
`ifdef ST2_MULDIV_STALL_EN
            // EX is busy with the multiply/divide, so a taken branch is ignored.
            MULDIV: begin
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                if (cnt_q <= CNT_W'(1)) state_d = RUN;
            end
`endif
            HALT: state_d = HALT;
            default: state_d = RST_HOLD;
        endcase
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.se_sel      = decode_se(opcode);
    assign bus.halted      = (state_q == HALT);
    assign bus.reg_write   = dec_ctrl.reg_write & ~idex_bubble;
    assign bus.mem_read    = dec_ctrl.mem_read  & ~idex_bubble;
    assign bus.mem_write   = dec_ctrl.mem_write & ~idex_bubble;
    assign bus.alu_src     = dec_ctrl.alu_src   & ~idex_bubble;
    assign bus.branch      = dec_ctrl.branch    & ~idex_bubble;
    assign bus.jump        = dec_ctrl.jump      & ~idex_bubble;

endmodule
